mult_seq: RTL and testbench
===========================

Name: mult_seq

Overview:
- Multi-cycle shift-and-add integer multiplier for the execute stage.
- Consumes the same two operand buses that feed the combinational ALU, and returns a 2*WIDTH-bit product as separate hi and lo words for the register writeback mux.
- Supports signed and unsigned operation.
- Uses a start/busy/done handshake so the pipeline controller can stall while a multiply is in progress.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset, sampled on rising clk edge
start  input  1  request a multiply; sampled only while idle
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
src_a  input  WIDTH  multiplicand; captured with start
src_b  input  WIDTH  multiplier; captured with start
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse: prod_hi/prod_lo hold a new result
prod_hi  output  WIDTH  upper WIDTH bits of the product
prod_lo  output  WIDTH  lower WIDTH bits of the product

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: busy=0, done=0, prod_hi=0, prod_lo=0, state=IDLE, iteration counter=0.
- Reset mid-operation: rst wins over everything. The next cycle shows the reset values and the in-flight result is discarded.
- IDLE state:
  - start=1 at the edge ending cycle T captures src_a, src_b and is_signed.
  - In signed mode, operand magnitudes are stored and the result sign is recorded as a_sign XOR b_sign.
  - The magnitude of 0x8000_0000 is 0x8000_0000, interpreted as unsigned.
  - Transition to RUN with counter=0.
- RUN state:
  - Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH+1-bit accumulator. The extra bit is the carry.
  - Then shift the accumulator right by 1.
  - Counter increments each cycle. After exactly WIDTH RUN cycles (cycles T+1..T+WIDTH), go to FIX.
  - No early termination: latency is independent of operand values, including zero.
- FIX state (cycle T+WIDTH+1):
  - If signed and the result sign is 1, two's-complement negate the full 2*WIDTH result; otherwise pass it through.
  - At the edge ending FIX, load prod_hi/prod_lo, set done=1 and return to IDLE.
- busy: 1 in cycles T+1 through T+WIDTH+1 inclusive, WIDTH+1 cycles total.
- done:
  - 1 only in cycle T+WIDTH+2.
  - Start-to-done latency is WIDTH+2 cycles (34 for WIDTH=32).
- Outputs hold: prod_hi/prod_lo change only at the edge that raises done, or on reset. They hold the last result indefinitely.
- start while busy=1: ignored. Operands are not recaptured and the in-flight result is unaffected.
- start in the done cycle: accepted, because the block is IDLE. busy rises the next cycle, which allows back-to-back multiplies with no gap cycle.
- src_a, src_b and is_signed changing during RUN/FIX: no effect.
- Unsigned arithmetic is exact modulo 2^(2*WIDTH). Signed arithmetic is exact over the full range, including the most-negative operand.

Test Plan:
1. Reset, then an unsigned multiply.
   - Stimulus: rst=1 for 2 cycles, then start with is_signed=0, src_a=0x0000_0007, src_b=0x0000_0006.
   - Required: busy high exactly 33 cycles; done pulses 34 cycles after the start cycle; prod_hi=0x0000_0000, prod_lo=0x0000_002A.
2. Unsigned maximum.
   - Stimulus: src_a=src_b=0xFFFF_FFFF, is_signed=0.
   - Required: prod_hi=0xFFFF_FFFE, prod_lo=0x0000_0001.
3. Signed cases.
   - -3 × 5, is_signed=1 -> prod_hi=0xFFFF_FFFF, prod_lo=0xFFFF_FFF1.
   - 0x8000_0000 × 0x8000_0000, is_signed=1 -> prod_hi=0x4000_0000, prod_lo=0x0000_0000.
   - The same operands with is_signed=0 -> prod_hi=0x4000_0000, prod_lo=0x0000_0000.
4. Start and operand changes during an operation.
   - Stimulus: start 2×3; pulse start with 9×9 at cycle T+10; change src_a/src_b during RUN.
   - Required: result 6; only one done pulse; no second busy period.
5. Back-to-back multiplies.
   - Stimulus: start 4×4; assert start with 0 × 0x1234_5678 in the done cycle.
   - Required: first result 16 held; busy rises next cycle; second done exactly 34 cycles later with prod_hi=prod_lo=0.
6. Reset mid-operation.
   - Stimulus: start 5×5; assert rst at cycle T+15 for 1 cycle.
   - Required: next cycle busy=0, done=0, prod=0, and no done pulse follows. A fresh start 5×5 then yields prod_lo=0x19 after 34 cycles.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier, signed/unsigned, 2*WIDTH-bit product.
// Start/busy/done handshake; fixed latency of WIDTH+2 cycles start-to-done.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   acc;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_add;
    logic [2*WIDTH-1:0] prod_full;

    // Most-negative operand negates to itself, which is its correct unsigned magnitude.
    assign mag_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    assign sum       = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    assign acc_add   = acc[0] ? {sum, acc[WIDTH-1:0]} : acc;
    assign prod_full = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= mag_a;
                        acc   <= {{(WIDTH+1){1'b0}}, mag_b};
                        neg   <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_add >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    prod_hi <= prod_full[2*WIDTH-1:WIDTH];
                    prod_lo <= prod_full[WIDTH-1:0];
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: expected products queued at start,
// checked with latency and busy length when done pulses.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;

    mult_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = s ? {{32{a[31]}}, a} : {32'b0, a};
        xb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy_len = 0;
        end else begin
            if (busy) begin
                busy_len++;
            end else if (busy_len != 0) begin
                chk("busy_len", 64'(busy_len), 64'd33);
                busy_len = 0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("prod_hi", {32'b0, prod_hi}, {32'b0, e.prod[63:32]});
                    chk("prod_lo", {32'b0, prod_lo}, {32'b0, e.prod[31:0]});
                    chk("latency", 64'(cyc - e.t), 64'd34);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input bit push);
        start     = 1'b1;
        src_a     = a;
        src_b     = b;
        is_signed = s;
        if (push) sb.push_back('{model(a, b, s), cyc});
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        if (!done) chk(tag, 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input string tag);
        start_op(a, b, s, 1'b1);
        wait_done(tag);
        step();
        step();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        src_a     = '0;
        src_b     = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
        step();

        run_op(32'h7, 32'h6, 1'b0, "t1_timeout");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "t2_timeout");
        run_op(32'hFFFF_FFFD, 32'h5, 1'b1, "t3a_timeout");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "t3b_timeout");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "t3c_timeout");
        run_op(32'h8000_0001, 32'h7FFF_FFFF, 1'b1, "t3d_timeout");
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 1'(i), "rand_timeout");
        end

        start_op(32'h2, 32'h3, 1'b0, 1'b1);
        repeat (9) step();
        start_op(32'h9, 32'h9, 1'b0, 1'b0);
        src_a     = 32'hFFFF_0000;
        src_b     = 32'h1234_5678;
        is_signed = 1'b1;
        wait_done("t4_timeout");
        repeat (40) step();
        chk("t4_idle", {63'b0, busy}, 64'd0);
        chk("t4_held", {prod_hi, prod_lo}, 64'd6);

        start_op(32'h5, 32'h5, 1'b0, 1'b0);
        repeat (14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", {63'b0, busy}, 64'd0);
        chk("t6_done", {63'b0, done}, 64'd0);
        chk("t6_prod", {prod_hi, prod_lo}, 64'd0);
        repeat (50) step();
        run_op(32'h5, 32'h5, 1'b0, "t6_timeout");

        start_op(32'h4, 32'h4, 1'b0, 1'b1);
        wait_done("t5a_timeout");
        start     = 1'b1;
        src_a     = 32'h0;
        src_b     = 32'h1234_5678;
        is_signed = 1'b0;
        sb.push_back('{64'd0, cyc});
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("t5_busy_rise", {63'b0, busy}, 64'd1);
        chk("t5_held", {prod_hi, prod_lo}, 64'd16);
        wait_done("t5b_timeout");
        repeat (5) step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
